// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 fetch stage:
// instruction codes, register sentinel, status codes and fetch FSM states.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        AOK = 2'd0,
        HLT = 2'd1,
        ADR = 2'd2,
        INS = 2'd3
    } stat_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE,
        S_HALTED
    } fstate_t;

endpackage

// File: rtl/y86_ilen_decode.sv
// Combinational instruction-format decoder: length, register byte,
// constant presence/offset and opcode validity from icode/ifun.
// Ports: icode, ifun in; len, need_regs, need_valc, valc_off, instr_valid out.
module y86_ilen_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic [3:0] len,
    output logic       need_regs,
    output logic       need_valc,
    output logic [1:0] valc_off,
    output logic       instr_valid
);

    always_comb begin
        len         = 4'd1;
        need_regs   = 1'b0;
        need_valc   = 1'b0;
        valc_off    = 2'd1;
        instr_valid = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                instr_valid = (ifun == 4'd0);
            end
            I_RRMOVQ: begin
                len         = 4'd2;
                need_regs   = 1'b1;
                instr_valid = (ifun <= 4'd6);
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                len         = 4'd10;
                need_regs   = 1'b1;
                need_valc   = 1'b1;
                valc_off    = 2'd2;
                instr_valid = (ifun == 4'd0);
            end
            I_OPQ: begin
                len         = 4'd2;
                need_regs   = 1'b1;
                instr_valid = (ifun <= 4'd3);
            end
            I_JXX: begin
                len         = 4'd9;
                need_valc   = 1'b1;
                instr_valid = (ifun <= 4'd6);
            end
            I_CALL: begin
                len         = 4'd9;
                need_valc   = 1'b1;
                instr_valid = (ifun == 4'd0);
            end
            I_PUSHQ, I_POPQ: begin
                len         = 4'd2;
                need_regs   = 1'b1;
                instr_valid = (ifun == 4'd0);
            end
            default: begin
                instr_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: reads an instruction a byte per beat, splits fields,
// computes valP/stat and holds the result under a valid/ready handshake.
// Ports: pc_in/pc_valid/pc_ready from PC update; imem_* byte memory port;
// out_valid/out_ready plus icode, ifun, rA, rB, valC, valP, stat to decode.
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int MAX_LEN = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_rdata,
    input  logic              imem_valid,
    input  logic              imem_error,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic [1:0]        stat
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    fstate_t           state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        icode_q, icode_d;
    logic [3:0]        ifun_q, ifun_d;
    logic [3:0]        ra_q, ra_d;
    logic [3:0]        rb_q, rb_d;
    logic [63:0]       valc_q, valc_d;
    logic [ADDR_W-1:0] valp_q, valp_d;
    stat_t             stat_q, stat_d;

    logic              first;
    logic [3:0]        dec_icode;
    logic [3:0]        dec_ifun;
    logic [3:0]        len;
    logic              need_regs;
    logic              need_valc;
    logic [1:0]        valc_off;
    logic              instr_valid;
    logic [CNT_W-1:0]  cnt_inc;
    logic [2:0]        vbyte;

    // Byte 0 is decoded straight off the bus; later bytes use the
    // captured opcode so a single decoder serves every beat.
    assign first     = (cnt_q == '0);
    assign dec_icode = first ? imem_rdata[7:4] : icode_q;
    assign dec_ifun  = first ? imem_rdata[3:0] : ifun_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign vbyte     = 3'(cnt_q - CNT_W'(valc_off));

    y86_ilen_decode u_dec (
        .icode       (dec_icode),
        .ifun        (dec_ifun),
        .len         (len),
        .need_regs   (need_regs),
        .need_valc   (need_valc),
        .valc_off    (valc_off),
        .instr_valid (instr_valid)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        icode_d  = icode_q;
        ifun_d   = ifun_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        valc_d   = valc_q;
        valp_d   = valp_q;
        stat_d   = stat_q;
        pc_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_ready = 1'b1;
            end
            S_FETCH: begin
                if (imem_valid) begin
                    cnt_d = cnt_inc;
                    if (imem_error) begin
                        stat_d  = ADR;
                        valp_d  = pc_q;
                        state_d = S_DONE;
                    end else if (first) begin
                        icode_d = imem_rdata[7:4];
                        ifun_d  = imem_rdata[3:0];
                        if (!instr_valid) begin
                            stat_d  = INS;
                            valp_d  = pc_q + ADDR_W'(1);
                            state_d = S_DONE;
                        end else begin
                            stat_d = (imem_rdata[7:4] == I_HALT) ? HLT : AOK;
                            valp_d = pc_q + ADDR_W'(len);
                            if (cnt_inc == CNT_W'(len)) begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        if (need_regs && cnt_q == CNT_W'(1)) begin
                            ra_d = imem_rdata[7:4];
                            rb_d = imem_rdata[3:0];
                        end
                        if (need_valc && cnt_q >= CNT_W'(valc_off)) begin
                            valc_d[{vbyte, 3'b000} +: 8] = imem_rdata;
                        end
                        if (cnt_inc == CNT_W'(len)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                pc_ready = out_ready && (stat_q == AOK);
                if (out_ready) begin
                    state_d = (stat_q == AOK) ? S_IDLE : S_HALTED;
                end
            end
            S_HALTED: begin
                pc_ready = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // New PC taken from IDLE or straight out of DONE on handshake.
        if (pc_ready && pc_valid) begin
            pc_d    = pc_in;
            cnt_d   = '0;
            icode_d = 4'h0;
            ifun_d  = 4'h0;
            ra_d    = RNONE;
            rb_d    = RNONE;
            valc_d  = '0;
            stat_d  = AOK;
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= RNONE;
            rb_q    <= RNONE;
            valc_q  <= '0;
            valp_q  <= '0;
            stat_q  <= AOK;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            stat_q  <= stat_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q + ADDR_W'(cnt_q);
    assign out_valid = (state_q == S_DONE);
    assign icode     = icode_q;
    assign ifun      = ifun_q;
    assign rA        = ra_q;
    assign rB        = rb_q;
    assign valC      = valc_q;
    assign valP      = valp_q;
    assign stat      = stat_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Scoreboard bench for y86_fetch_unit: directed programs in a byte memory,
// expected decodes queued at issue and checked by a monitor on handshake.
module tb_y86_fetch_unit;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        imem_valid;
    logic        imem_error;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [1:0]  stat;

    always #5 clk = ~clk;

    y86_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .imem_error (imem_error),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .valP       (valP),
        .stat       (stat)
    );

    // Byte memory, indexed by the low 12 address bits.
    logic [7:0]  mem [0:4095];
    logic        err_en;
    logic [63:0] err_addr;
    logic [63:0] stall_addr;
    int          stall_n;
    int          stall_used;
    logic        stalling;

    assign stalling   = imem_req && (imem_addr == stall_addr) && (stall_used < stall_n);
    assign imem_valid = imem_req && !stalling;
    assign imem_error = imem_req && err_en && (imem_addr == err_addr);
    assign imem_rdata = mem[imem_addr[11:0]];

    always @(posedge clk) begin
        if (reset) stall_used <= 0;
        else if (stalling) stall_used <= stall_used + 1;
    end

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [1:0]  stat;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor
    int          cyc = 0;
    int          acc_cyc = 0;
    int          lat = 0;
    logic        ov_prev = 1'b0;
    logic        stall_prev = 1'b0;
    logic [63:0] stall_addr_prev = '0;
    exp_t        e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            ov_prev    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) chk("addr_held", imem_addr, stall_addr_prev);
            stall_prev      = imem_req && !imem_valid;
            stall_addr_prev = imem_addr;
            if (out_valid && !ov_prev) lat = cyc - acc_cyc;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: got icode %h expected none", icode);
                end else begin
                    e = q.pop_front();
                    chk("icode", 64'(icode), 64'(e.icode));
                    chk("ifun", 64'(ifun), 64'(e.ifun));
                    chk("rA", 64'(rA), 64'(e.ra));
                    chk("rB", 64'(rB), 64'(e.rb));
                    chk("valC", valC, e.valc);
                    chk("valP", valP, e.valp);
                    chk("stat", 64'(stat), 64'(e.stat));
                    chk("latency", 64'(lat), 64'(e.lat));
                end
            end
            if (pc_valid && pc_ready) acc_cyc = cyc + 1;
            ov_prev = out_valid;
        end
    end

    task automatic put(input logic [63:0] a, input logic [7:0] b);
        mem[a[11:0]] = b;
    endtask

    task automatic push(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic [63:0] vp,
                        input logic [1:0] st, input int lt);
        exp_t x;
        x.icode = ic; x.ifun = fn; x.ra = ra; x.rb = rb;
        x.valc = vc; x.valp = vp; x.stat = st; x.lat = lt;
        q.push_back(x);
    endtask

    task automatic issue(input logic [63:0] pc);
        int   b;
        logic acc;
        b = 0;
        acc = 1'b0;
        pc_in = pc;
        pc_valid = 1'b1;
        while (!acc && b < 50) begin
            acc = pc_ready;
            @(posedge clk);
            #1;
            b++;
        end
        pc_valid = 1'b0;
        if (!acc) chk("pc_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (q.size() != 0 && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic halted_chk();
        pc_in = 64'h710;
        pc_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("halt_pc_ready", 64'(pc_ready), 64'd0);
        chk("halt_out_valid", 64'(out_valid), 64'd0);
        chk("halt_imem_req", 64'(imem_req), 64'd0);
        pc_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] irm [10];
        logic [7:0] jmp [9];
        logic [7:0] rmm [10];
        int b;
        irm = '{8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        jmp = '{8'h73, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rmm = '{8'h40, 8'h12, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        reset = 1'b1;
        pc_in = '0;
        pc_valid = 1'b0;
        out_ready = 1'b1;
        err_en = 1'b0;
        err_addr = '0;
        stall_addr = '1;
        stall_n = 0;
        repeat (2) begin @(posedge clk); #1; end

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pc_ready", 64'(pc_ready), 64'd1);
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_icode", 64'(icode), 64'd0);
        chk("rst_rA", 64'(rA), 64'hF);
        chk("rst_rB", 64'(rB), 64'hF);
        chk("rst_valC", valC, 64'd0);
        chk("rst_valP", valP, 64'd0);
        chk("rst_stat", 64'(stat), 64'd0);
        reset = 1'b0;

        // nop
        put(64'h0, 8'h10);
        push(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, AOK, 1);
        issue(64'h0);
        drain();
        chk("nop_idle_ready", 64'(pc_ready), 64'd1);
        chk("nop_idle_req", 64'(imem_req), 64'd0);

        // irmovq
        for (int i = 0; i < 10; i++) put(64'h100 + 64'(i), irm[i]);
        push(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'h10A, AOK, 10);
        issue(64'h100);
        drain();

        // jXX with a 3-cycle stall on byte 4
        for (int i = 0; i < 9; i++) put(64'h200 + 64'(i), jmp[i]);
        stall_addr = 64'h204;
        stall_n = 3;
        push(4'h7, 4'h3, 4'hF, 4'hF, 64'h40, 64'h209, AOK, 12);
        issue(64'h200);
        drain();

        // backpressure, then back-to-back issue on the handshake edge
        put(64'h300, 8'h10);
        put(64'h310, 8'h20);
        put(64'h311, 8'h12);
        out_ready = 1'b0;
        push(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h301, AOK, 1);
        issue(64'h300);
        b = 0;
        while (!out_valid && b < 20) begin @(posedge clk); #1; b++; end
        repeat (4) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_valP", valP, 64'h301);
            chk("bp_pc_ready", 64'(pc_ready), 64'd0);
        end
        push(4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'h312, AOK, 2);
        out_ready = 1'b1;
        pc_in = 64'h310;
        pc_valid = 1'b1;
        #1;
        chk("b2b_pc_ready", 64'(pc_ready), 64'd1);
        @(posedge clk); #1;
        pc_valid = 1'b0;
        chk("b2b_imem_req", 64'(imem_req), 64'd1);
        chk("b2b_imem_addr", imem_addr, 64'h310);
        drain();

        // address wrap
        put(64'hFFF, 8'h20);
        put(64'h0, 8'h45);
        push(4'h2, 4'h0, 4'h4, 4'h5, 64'd0, 64'd1, AOK, 2);
        issue(64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        chk("wrap_addr1", imem_addr, 64'h0);
        drain();

        // halt
        put(64'h700, 8'h00);
        push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h701, HLT, 1);
        issue(64'h700);
        drain();
        halted_chk();
        do_reset();

        // bad ifun
        put(64'h400, 8'h65);
        push(4'h6, 4'h5, 4'hF, 4'hF, 64'd0, 64'h401, INS, 1);
        issue(64'h400);
        drain();
        halted_chk();
        do_reset();

        // bad icode
        put(64'h500, 8'hC0);
        push(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h501, INS, 1);
        issue(64'h500);
        drain();
        halted_chk();
        do_reset();

        // rmmovq with a fault on byte 5
        for (int i = 0; i < 10; i++) put(64'h600 + 64'(i), rmm[i]);
        err_en = 1'b1;
        err_addr = 64'h605;
        push(4'h4, 4'h0, 4'h1, 4'h2, 64'h332211, 64'h600, ADR, 6);
        issue(64'h600);
        drain();
        halted_chk();
        err_en = 1'b0;
        do_reset();

        // reset in the middle of a fetch
        issue(64'h100);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_imem_req", 64'(imem_req), 64'd0);
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_pc_ready", 64'(pc_ready), 64'd1);
        chk("mid_icode", 64'(icode), 64'd0);
        chk("mid_rB", 64'(rB), 64'hF);
        chk("mid_valC", valC, 64'd0);
        chk("mid_valP", valP, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_idle_req", 64'(imem_req), 64'd0);

        repeat (2) begin @(posedge clk); #1; end
        chk("final_queue", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
